// File: rtl/iomem_pkg.sv
// Shared types and constants for the PicoSoC iomem page router.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    CAUSE_UNMAPPED = 1'b0,
    CAUSE_TIMEOUT  = 1'b1
  } err_cause_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_10E5;
  localparam logic [7:0]  PAGE_GPIO    = 8'h03;
  localparam logic [7:0]  PAGE_DIP     = 8'h04;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/iomem_wdt.sv
// Clearable 8-bit up-counter with a terminal-count flag, used as the slave wait watchdog.
module iomem_wdt #(
  parameter logic [7:0] TC = 8'd63
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC);

endmodule

// File: rtl/iomem_router.sv
// Routes one iomem transaction at a time to a slave selected by addr[31:24].
// Define IOMEM_ROUTER_TIMEOUT_EN to abort hung slaves after TIMEOUT busy cycles.
module iomem_router
  import iomem_pkg::*;
#(
  parameter int          NSLAVES   = 4,
  parameter logic [7:0]  BASE_PAGE = 8'h03,
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   m_valid,
  input  logic [3:0]             m_wstrb,
  input  logic [31:0]            m_addr,
  input  logic [31:0]            m_wdata,
  output logic                   m_ready,
  output logic [31:0]            m_rdata,
  output logic [NSLAVES-1:0]     s_valid,
  output logic [3:0]             s_wstrb,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  input  logic [NSLAVES-1:0]     s_ready,
  input  logic [32*NSLAVES-1:0]  s_rdata,
  output logic                   err_pulse,
  output logic                   err_timeout,
  output logic [31:0]            err_addr,
  output logic [7:0]             err_count
);

  localparam int SELW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  state_e              state_q, state_d;
  logic [NSLAVES-1:0]  s_valid_q, s_valid_d;
  logic [3:0]          s_wstrb_q, s_wstrb_d;
  logic [31:0]         s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic                m_ready_q, m_ready_d, err_pulse_q, err_pulse_d;
  logic [31:0]         m_rdata_q, m_rdata_d, err_addr_q, err_addr_d;
  logic                err_timeout_q, err_timeout_d;
  logic [7:0]          err_count_q, err_count_d;

  logic [8:0]          page_off_s;
  logic                mapped_s, ready_sel_s, timeout_s;
  logic [SELW-1:0]     sel_in_s;
  logic [31:0]         rdata_sel_s;

  // Pages below BASE_PAGE wrap to >= 256 in the 9-bit offset and fall out of range
  assign page_off_s  = {1'b0, m_addr[31:24]} - {1'b0, BASE_PAGE};
  assign mapped_s    = (page_off_s < 9'(NSLAVES));
  assign sel_in_s    = page_off_s[SELW-1:0];
  assign ready_sel_s = s_ready[sel_q] & s_valid_q[sel_q];
  assign rdata_sel_s = s_rdata[{sel_q, 5'd0} +: 32];

`ifdef IOMEM_ROUTER_TIMEOUT_EN
  iomem_wdt #(
    .TC(8'(TIMEOUT - 1))
  ) u_wdt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state_q != ST_BUSY),
    .en     (state_q == ST_BUSY),
    .tc     (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Transaction sequencing and next values of every registered output
  always_comb begin
    state_d       = state_q;
    s_valid_d     = s_valid_q;
    s_wstrb_d     = s_wstrb_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    sel_d         = sel_q;
    m_ready_d     = 1'b0;
    m_rdata_d     = m_rdata_q;
    err_pulse_d   = 1'b0;
    err_timeout_d = err_timeout_q;
    err_addr_d    = err_addr_q;
    err_count_d   = err_count_q;
    case (state_q)
      ST_IDLE: begin
        if (m_valid && !m_ready_q) begin
          s_addr_d  = m_addr;
          s_wstrb_d = m_wstrb;
          s_wdata_d = m_wdata;
          if (mapped_s) begin
            s_valid_d = NSLAVES'(1) << sel_in_s;
            sel_d     = sel_in_s;
            state_d   = ST_BUSY;
          end else begin
            state_d       = ST_RESP;
            m_ready_d     = 1'b1;
            m_rdata_d     = ERR_DATA;
            err_pulse_d   = 1'b1;
            err_timeout_d = CAUSE_UNMAPPED;
            err_addr_d    = m_addr;
            err_count_d   = sat_inc8(err_count_q);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A ready arriving in the abort cycle still completes normally
        if (ready_sel_s) begin
          s_valid_d = '0;
          m_rdata_d = rdata_sel_s;
          m_ready_d = 1'b1;
          state_d   = ST_RESP;
        end else if (timeout_s) begin
          s_valid_d     = '0;
          m_ready_d     = 1'b1;
          m_rdata_d     = ERR_DATA;
          err_pulse_d   = 1'b1;
          err_timeout_d = CAUSE_TIMEOUT;
          err_addr_d    = s_addr_q;
          err_count_d   = sat_inc8(err_count_q);
          state_d       = ST_RESP;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        s_valid_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      s_valid_q     <= '0;
      s_wstrb_q     <= 4'd0;
      s_addr_q      <= 32'd0;
      s_wdata_q     <= 32'd0;
      sel_q         <= '0;
      m_ready_q     <= 1'b0;
      m_rdata_q     <= 32'd0;
      err_pulse_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_addr_q    <= 32'd0;
      err_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      s_valid_q     <= s_valid_d;
      s_wstrb_q     <= s_wstrb_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      sel_q         <= sel_d;
      m_ready_q     <= m_ready_d;
      m_rdata_q     <= m_rdata_d;
      err_pulse_q   <= err_pulse_d;
      err_timeout_q <= err_timeout_d;
      err_addr_q    <= err_addr_d;
      err_count_q   <= err_count_d;
    end
  end

  assign m_ready     = m_ready_q;
  assign m_rdata     = m_rdata_q;
  assign s_valid     = s_valid_q;
  assign s_wstrb     = s_wstrb_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign err_pulse   = err_pulse_q;
  assign err_timeout = err_timeout_q;
  assign err_addr    = err_addr_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_iomem_router.sv
// Randomized self-checking bench for iomem_router against a transaction-level model.
module tb_iomem_router;

  localparam int          NS  = 4;
  localparam logic [7:0]  BP  = 8'h03;
  localparam int          TO  = 8;
  localparam logic [31:0] ED  = 32'hDEAD_10E5;
`ifdef IOMEM_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk, resetn;
  logic            m_valid, m_ready, err_pulse, err_timeout;
  logic [3:0]      m_wstrb, s_wstrb;
  logic [31:0]     m_addr, m_wdata, m_rdata, s_addr, s_wdata, err_addr;
  logic [NS-1:0]   s_valid, s_ready;
  logic [32*NS-1:0] s_rdata;
  logic [7:0]      err_count;

  iomem_router #(.NSLAVES(NS), .BASE_PAGE(BP), .TIMEOUT(TO), .ERR_DATA(ED)) dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_pulse(err_pulse), .err_timeout(err_timeout), .err_addr(err_addr), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model of architectural state
  logic [31:0] md_rdata, md_err_addr, md_saddr, md_swdata;
  logic [3:0]  md_swstrb;
  logic        md_err_to;
  int          md_err_cnt;
  // Per-cycle expectations
  logic [NS-1:0] ex_sv;
  logic          ex_mr, ex_ep;
  bit            chk_en = 1'b0;
  int            cur_cyc, mr_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_valid",     32'(s_valid),     32'(ex_sv));
      chk("m_ready",     32'(m_ready),     32'(ex_mr));
      chk("err_pulse",   32'(err_pulse),   32'(ex_ep));
      chk("m_rdata",     m_rdata,          md_rdata);
      chk("err_timeout", 32'(err_timeout), 32'(md_err_to));
      chk("err_addr",    err_addr,         md_err_addr);
      chk("err_count",   32'(err_count),   32'(md_err_cnt));
      chk("s_addr",      s_addr,           md_saddr);
      chk("s_wdata",     s_wdata,          md_swdata);
      chk("s_wstrb",     32'(s_wstrb),     32'(md_swstrb));
      if (m_ready === 1'b1) mr_cyc = cur_cyc;
    end
  end

  task automatic model_clear();
    md_rdata = 32'd0; md_err_addr = 32'd0; md_saddr = 32'd0; md_swdata = 32'd0;
    md_swstrb = 4'd0; md_err_to = 1'b0; md_err_cnt = 0;
    ex_sv = '0; ex_mr = 1'b0; ex_ep = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      m_valid = 1'b0;
      m_addr  = $urandom;
      s_ready = NS'($urandom);
      ex_sv = '0; ex_mr = 1'b0; ex_ep = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // One transaction; slave 'sel' raises ready k cycles after its s_valid rises
  task automatic do_txn(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                        input int k, input logic [31:0] sd);
    int pg, sel, lat, sv_last;
    bit mapped, timed_out, err;
    logic [31:0] noise;
    pg        = int'(addr[31:24]);
    mapped    = (pg >= int'(BP)) && (pg < int'(BP) + NS);
    sel       = mapped ? pg - int'(BP) : 0;
    timed_out = mapped && TO_EN && (k >= TO);
    lat       = !mapped ? 1 : (timed_out ? TO + 1 : k + 2);
    sv_last   = mapped ? lat - 1 : 0;
    err       = !mapped || timed_out;
    mr_cyc    = -1;
    for (int c = 0; c <= lat; c++) begin
      cur_cyc = c;
      m_valid = 1'b1; m_addr = addr; m_wstrb = ws; m_wdata = wd;
      noise   = $urandom;
      s_ready = noise[NS-1:0];
      if (mapped && c >= 1 && c <= sv_last) s_ready[sel] = (c == k + 1);
      for (int s = 0; s < NS; s++) s_rdata[32*s +: 32] = $urandom;
      if (mapped) s_rdata[32*sel +: 32] = sd;
      if (c == 1) begin
        md_saddr = addr; md_swdata = wd; md_swstrb = ws;
      end
      ex_sv = (mapped && c >= 1 && c <= sv_last) ? NS'(1 << sel) : '0;
      ex_mr = (c == lat);
      ex_ep = (c == lat) && err;
      if (c == lat) begin
        md_rdata = err ? ED : sd;
        if (err) begin
          md_err_addr = addr;
          md_err_to   = timed_out;
          if (md_err_cnt < 255) md_err_cnt++;
        end
      end
      @(posedge clk); #1;
    end
    m_valid = 1'b0;
  endtask

  logic [7:0] rpg;

  initial begin
    resetn = 1'b0; m_valid = 1'b0; m_wstrb = 4'd0; m_addr = 32'd0; m_wdata = 32'd0;
    s_ready = '0; s_rdata = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst s_valid",   32'(s_valid),   32'd0);
    chk("rst m_ready",   32'(m_ready),   32'd0);
    chk("rst m_rdata",   m_rdata,        32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    chk("rst s_addr",    s_addr,         32'd0);
    resetn = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Directed: write to GPIO slave, same-cycle ready
    do_txn(32'h0300_0000, 4'hF, 32'h1234_5678, 0, 32'h0000_0000);
    chk("t1 latency", 32'(mr_cyc), 32'd2);
    chk("t1 s_wdata", s_wdata, 32'h1234_5678);
    chk("t1 no err",  32'(err_count), 32'd0);
    // Directed: read from DIP slave with 3 wait cycles
    do_txn(32'h0400_0000, 4'h0, 32'h0, 3, 32'h00AB_CDEF);
    chk("t2 latency", 32'(mr_cyc), 32'd5);
    chk("t2 rdata",   m_rdata, 32'h00AB_CDEF);
    // Directed: unmapped page
    do_txn(32'h0900_0000, 4'h0, 32'h0, 0, 32'h0);
    chk("t3 latency",  32'(mr_cyc), 32'd1);
    chk("t3 rdata",    m_rdata, 32'hDEAD_10E5);
    chk("t3 err_to",   32'(err_timeout), 32'd0);
    chk("t3 err_addr", err_addr, 32'h0900_0000);
    chk("t3 err_cnt",  32'(err_count), 32'd1);
    idle(1);
    if (TO_EN) begin
      do_txn(32'h0500_0000, 4'h0, 32'h0, 1000, 32'h5555_AAAA);
      chk("t4 latency", 32'(mr_cyc), 32'd9);
      chk("t4 err_to",  32'(err_timeout), 32'd1);
      chk("t4 rdata",   m_rdata, 32'hDEAD_10E5);
      do_txn(32'h0500_0004, 4'h0, 32'h0, 7, 32'h0BAD_F00D);
      chk("t5 latency", 32'(mr_cyc), 32'd9);
      chk("t5 rdata",   m_rdata, 32'h0BAD_F00D);
      chk("t5 err_cnt", 32'(err_count), 32'd2);
    end else begin
      do_txn(32'h0500_0000, 4'h0, 32'h0, 100, 32'h0BAD_F00D);
      chk("t4 latency", 32'(mr_cyc), 32'd102);
      chk("t4 rdata",   m_rdata, 32'h0BAD_F00D);
      chk("t4 err_cnt", 32'(err_count), 32'd1);
    end

    // Randomized traffic, back-to-back with occasional gaps
    for (int i = 0; i < 200; i++) begin
      rpg = 8'($urandom_range(1, 10));
      if ($urandom_range(0, 15) == 0) rpg = 8'hFF;
      do_txn({rpg, 24'($urandom)}, 4'($urandom), $urandom,
             $urandom_range(0, TO_EN ? 12 : 15), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Error counter saturation
    for (int i = 0; i < 300; i++) do_txn({8'h20, 24'(i)}, 4'h0, 32'h0, 0, 32'h0);
    chk("sat err_cnt", 32'(err_count), 32'd255);

    // Asynchronous reset in the middle of a BUSY transaction
    chk_en  = 1'b0;
    m_valid = 1'b1; m_addr = 32'h0500_0010; m_wstrb = 4'h3; m_wdata = 32'hCAFE_0001;
    s_ready = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy s_valid", 32'(s_valid), 32'h4);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst s_valid",   32'(s_valid),   32'd0);
    chk("arst m_ready",   32'(m_ready),   32'd0);
    chk("arst err_count", 32'(err_count), 32'd0);
    m_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    model_clear();
    chk_en = 1'b1;
    idle(1);
    do_txn(32'h0600_0000, 4'hF, 32'h7777_8888, 2, 32'h1357_9BDF);
    chk("post-rst latency", 32'(mr_cyc), 32'd4);
    chk("post-rst rdata",   m_rdata, 32'h1357_9BDF);
    idle(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
